// File: rtl/mini_exec_stage.sv
// mini_exec_stage: execute stage of the mini CPU, fed by the two register-file read ports.
// It computes an ALU result, registers it and drives the register-file write port.
// Z and C flags describe the most recently written result.
// Optional feature macro: MINI_EXEC_MUL_EN.
//   Defined   : opcode 111 is an iterative shift-add multiply taking DATA_W steps.
//   Undefined : opcode 111 is accepted as a single-cycle NOP; there is no MUL state and no accumulator.
module mini_exec_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);

    localparam logic [2:0] OP_MUL = 3'b111;

    // Returns {carry, result} for every single-cycle opcode.
    function automatic logic [DATA_W:0] alu(input logic [2:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        r = '0;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {(a < b), a - b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {a[DATA_W-1], a[DATA_W-2:0], 1'b0};
            3'b110:  r = {1'b0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic              accept;
    logic [DATA_W:0]   alu_out;
    logic              mul_done;
    logic [DATA_W-1:0] mul_res;
    logic              mul_c;
    logic [ADDR_W-1:0] mul_dst_p1;

    assign accept  = in_valid & in_ready;
    assign alu_out = alu(in_op, in_a, in_b);

`ifdef MINI_EXEC_MUL_EN
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_p1;
    logic [DATA_W-1:0]   mul_a_p1;
    logic [DATA_W-1:0]   mul_b_p1;
    logic [2*DATA_W-1:0] acc_p1;
    logic [2*DATA_W-1:0] acc_next;
    logic                mul_last;

    // The final step's sum feeds the writeback directly, so the result lands on the step-DATA_W edge.
    assign acc_next = acc_p1 + (mul_b_p1[0] ? ({{DATA_W{1'b0}}, mul_a_p1} << cnt_p1) : '0);
    assign mul_last = (cnt_p1 == CNT_W'(DATA_W - 1));
    assign mul_res  = acc_next[DATA_W-1:0];
    assign mul_c    = |acc_next[2*DATA_W-1:DATA_W];

    // State register and step counter; a reset mid-multiply abandons it with no writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_p1  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
        end
    end

    // Next state: enter MUL on an accepted multiply, leave after the last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && (in_op == OP_MUL)) state_d = S_MUL;
            S_MUL:   if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs follow the state; mul_done marks the final shift-add step.
    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q == S_MUL);
        mul_done = (state_q == S_MUL) && mul_last;
    end

    // Multiply operands and accumulator: latched on accept, one shift-add per MUL cycle.
    always_ff @(posedge clk) begin
        if (accept && (in_op == OP_MUL)) begin
            mul_a_p1   <= in_a;
            mul_b_p1   <= in_b;
            mul_dst_p1 <= in_dst;
            acc_p1     <= '0;
        end else if (state_q == S_MUL) begin
            acc_p1   <= acc_next;
            mul_b_p1 <= mul_b_p1 >> 1;
        end
    end
`else
    assign in_ready   = 1'b1;
    assign busy       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_res    = '0;
    assign mul_c      = 1'b0;
    assign mul_dst_p1 = '0;
`endif

    // Writeback stage: register result and flags; wb_we pulses only when a result is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            wb_we <= 1'b0;
            if (mul_done) begin
                wb_we    <= 1'b1;
                wb_waddr <= mul_dst_p1;
                wb_wdata <= mul_res;
                flag_z   <= (mul_res == '0);
                flag_c   <= mul_c;
            end else if (accept && (in_op != OP_MUL)) begin
                wb_we    <= 1'b1;
                wb_waddr <= in_dst;
                wb_wdata <= alu_out[DATA_W-1:0];
                flag_z   <= (alu_out[DATA_W-1:0] == '0);
                flag_c   <= alu_out[DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_mini_exec_stage.sv
// Testbench for mini_exec_stage: scoreboard of expected writebacks with a separate monitor.
// Honours MINI_EXEC_MUL_EN the same way the design does.
module tb_mini_exec_stage;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = '0;
    logic [ADDR_W-1:0] in_dst = '0;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              flag_z;
    logic              flag_c;
    logic              busy;

    mini_exec_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_dst   (in_dst),
        .in_a     (in_a),
        .in_b     (in_b),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              z;
        logic              c;
        int                cyc;
        bit                is_mul;
    } exp_t;

    exp_t              sb[$];
    int                vectors = 0;
    int                miscompares = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_data = '0;
    logic              mz = 1'b0;
    logic              mc = 1'b0;
    bit                mul_pending = 1'b0;

`ifdef MINI_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [ADDR_W-1:0] dst,
                                   input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t        e;
        int unsigned ai;
        int unsigned bi;
        int unsigned full;
        ai = a;
        bi = b;
        e.addr = dst;
        e.c = 1'b0;
        e.cyc = 0;
        e.is_mul = 1'b0;
        case (op)
            3'd0: begin full = ai + bi; e.c = (full > 255); end
            3'd1: begin full = (ai + 256 - bi) % 256; e.c = (ai < bi); end
            3'd2: full = ai & bi;
            3'd3: full = ai | bi;
            3'd4: full = ai ^ bi;
            3'd5: begin full = ai * 2; e.c = (ai >= 128); end
            3'd6: full = bi;
            default: begin full = ai * bi; e.c = ((full / 256) != 0); e.is_mul = 1'b1; end
        endcase
        e.data = DATA_W'(full % 256);
        e.z = (e.data == '0);
        return e;
    endfunction

    // Monitor: compare every writeback against the scoreboard, and check holds/handshake otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (wb_we) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_wb: wb_we=1 waddr=%0d wdata=0x%0h, expected no write", wb_waddr, wb_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wb_cycle", cyc, e.cyc);
                    check("wb_waddr", wb_waddr, e.addr);
                    check("wb_wdata", wb_wdata, e.data);
                    check("flag_z", flag_z, e.z);
                    check("flag_c", flag_c, e.c);
                    last_addr = e.addr;
                    last_data = e.data;
                    mz = e.z;
                    mc = e.c;
                    if (e.is_mul) mul_pending = 1'b0;
                end
            end else begin
                check("hold_waddr", wb_waddr, last_addr);
                check("hold_wdata", wb_wdata, last_data);
                check("hold_flag_z", flag_z, mz);
                check("hold_flag_c", flag_c, mc);
            end
            check("busy", busy, MUL_EN ? mul_pending : 1'b0);
            check("in_ready", in_ready, MUL_EN ? !mul_pending : 1'b1);
        end
    end

    task automatic scramble_inputs();
        in_op  = 3'($urandom);
        in_dst = ADDR_W'($urandom);
        in_a   = DATA_W'($urandom);
        in_b   = DATA_W'($urandom);
    endtask

    // Present one op, hold it until accepted, then push its expected writeback.
    task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] dst,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         output int acc_cyc);
        exp_t e;
        logic rdy;
        int   waited;
        bit   done;
        in_valid = 1'b1;
        in_op = op;
        in_dst = dst;
        in_a = a;
        in_b = b;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 40) begin
                    $display("FAIL accept_timeout: in_ready low for %0d cycles, expected at most %0d", waited, DATA_W);
                    $fatal(1, "accept timeout");
                end
            end
        end
        acc_cyc = cyc;
        e = model(op, dst, a, b);
        if (!e.is_mul) begin
            e.cyc = cyc;
            sb.push_back(e);
        end else if (MUL_EN) begin
            e.cyc = cyc + DATA_W;
            sb.push_back(e);
            mul_pending = 1'b1;
        end
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        sb.delete();
        mul_pending = 1'b0;
        last_addr = '0;
        last_data = '0;
        mz = 1'b0;
        mc = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_waddr", wb_waddr, '0);
        check("rst_wdata", wb_wdata, '0);
        check("rst_flag_z", flag_z, 1'b0);
        check("rst_flag_c", flag_c, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            scramble_inputs();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0;
        int t1;
        int waited;
        do_reset(3);

        // ADD with carry out
        issue(3'd0, 2'd2, 8'hF0, 8'h20, t0);
        check("add_we", wb_we, 1'b1);
        check("add_waddr", wb_waddr, 2'd2);
        check("add_wdata", wb_wdata, 8'h10);
        check("add_c", flag_c, 1'b1);
        check("add_z", flag_z, 1'b0);

        // back-to-back SUB then XOR
        issue(3'd1, 2'd1, 8'h05, 8'h05, t0);
        check("sub_wdata", wb_wdata, 8'h00);
        check("sub_z", flag_z, 1'b1);
        check("sub_c", flag_c, 1'b0);
        issue(3'd4, 2'd3, 8'hAA, 8'h55, t1);
        check("b2b_gap", t1 - t0, 1);
        check("xor_we", wb_we, 1'b1);
        check("xor_waddr", wb_waddr, 2'd3);
        check("xor_wdata", wb_wdata, 8'hFF);
        check("xor_z", flag_z, 1'b0);
        idle(2);

        if (MUL_EN) begin
            // MUL with latency check
            issue(3'd7, 2'd0, 8'h12, 8'h10, t0);
            repeat (DATA_W) @(posedge clk);
            #1;
            check("mul_we", wb_we, 1'b1);
            check("mul_wdata", wb_wdata, 8'h20);
            check("mul_c", flag_c, 1'b1);
            check("mul_ready_back", in_ready, 1'b1);
            idle(2);
            // op held valid during MUL is taken only when in_ready returns
            issue(3'd7, 2'd1, 8'h0B, 8'h0D, t0);
            issue(3'd0, 2'd2, 8'h01, 8'h02, t1);
            check("held_op_accept_gap", t1 - t0, DATA_W + 1);
            idle(2);
            // reset aborts MUL: no writeback afterwards
            issue(3'd7, 2'd0, 8'h03, 8'h04, t0);
            repeat (4) @(posedge clk);
            #2;
            do_reset(1);
            idle(DATA_W + 4);
            check("abort_wdata", wb_wdata, 8'h00);
            check("abort_flag_c", flag_c, 1'b0);
            check("abort_busy", busy, 1'b0);
            issue(3'd0, 2'd1, 8'h01, 8'h01, t0);
            check("post_abort_add_we", wb_we, 1'b1);
            check("post_abort_add", wb_wdata, 8'h02);
        end else begin
            // op 111 is a one-cycle NOP that leaves flags alone
            issue(3'd0, 2'd1, 8'hFF, 8'h01, t0);
            issue(3'd7, 2'd2, 8'h12, 8'h10, t1);
            check("nop_accept_gap", t1 - t0, 1);
            @(negedge clk);
            check("nop_no_we", wb_we, 1'b0);
            check("nop_flag_z", flag_z, 1'b1);
            check("nop_flag_c", flag_c, 1'b1);
            check("nop_busy", busy, 1'b0);
            @(posedge clk);
            #1;
        end

        // randomized traffic with random idle gaps
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            issue(3'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), t0);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(posedge clk);
            waited++;
        end
        idle(2);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d writebacks still outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
